// File: rtl/uart_transmitter_pkg.sv
// Shared UART transmitter definitions: FSM state encoding, default frame
// timing, and counter width helper.
package uart_transmitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SB_TICKS   = 16;

  // Width able to hold 0..max(a,b)-1; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/uart_transmitter_piso.sv
// Parallel-in/serial-out shift register feeding the transmitter line,
// LSB first.
module parallel_input_serial_output_shift_register #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] d,
  output logic         s_out_bit
);

  logic [N-1:0] q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q >> 1;
    end
  end

  assign s_out_bit = q[0];

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, N data bits LSB first, stop period, paced by
// an oversampling tick. The line output is registered from the FSM state.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int N          = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICKS   = DEF_SB_TICKS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         shift_register_tick,
  input  logic         start,
  input  logic [N-1:0] data,
  output logic         s_out,
  output logic         busy,
  output logic         finish,
  output logic [1:0]   state_reg
);

  localparam int TW = cnt_width(OVERSAMPLE, SB_TICKS);
  localparam int BW = $clog2(N) + 1;

  localparam logic [TW-1:0] OVS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);

  // Handshake: start is a request sampled only while the FSM is idle
  // (busy low means ready); data is captured on the accepting edge only.
  tx_state_e     state;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sr_bit;
  logic          load;
  logic          shift;
  logic          line_nxt;

  assign load  = (state == ST_IDLE) && start;
  assign shift = (state == ST_DATA) && shift_register_tick && (tick_cnt == OVS_LAST);

  parallel_input_serial_output_shift_register #(.N(N)) u_piso (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .shift     (shift),
    .d         (data),
    .s_out_bit (sr_bit)
  );

  always_comb begin
    line_nxt = 1'b1;
    case (state)
      ST_START: line_nxt = 1'b0;
      ST_DATA:  line_nxt = sr_bit;
      default:  line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      s_out    <= 1'b1;
      busy     <= 1'b0;
      finish   <= 1'b0;
    end else begin
      finish <= 1'b0;
      s_out  <= line_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          if (shift_register_tick) begin
            if (tick_cnt == OVS_LAST) begin
              tick_cnt <= '0;
              state    <= ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (shift_register_tick) begin
            if (tick_cnt == OVS_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (shift_register_tick) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              finish   <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_reg = state;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: tick every 10 clk, 8N1 at 16x
// oversampling, so every data bit spans 160 clk.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       s_out;
  logic       busy;
  logic       finish;
  logic [1:0] state_reg;

  int total = 0;
  int bad = 0;
  int tick_mon = 0;
  int fin_cnt = 0;

  uart_transmitter #(.N(8), .OVERSAMPLE(16), .SB_TICKS(16)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .shift_register_tick (tick),
    .start               (start),
    .data                (data),
    .s_out               (s_out),
    .busy                (busy),
    .finish              (finish),
    .state_reg           (state_reg)
  );

  // clock / tick generation
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (9) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  // Ticks consumed by the FSM while a frame is active, and finish pulses.
  always @(negedge clk) begin
    if (busy === 1'b1 && tick === 1'b1) tick_mon++;
    if (finish === 1'b1) fin_cnt++;
  end

  // Bench-side receiver: find the start edge, sample each bit mid-period.
  task automatic rx_frame(output logic [7:0] b, output logic ok);
    int n;
    ok = 1'b1;
    b  = 8'h00;
    n  = 0;
    while (s_out !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (s_out !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (80) @(negedge clk);
    if (s_out !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (160) @(negedge clk);
      b[i] = s_out;
    end
    repeat (160) @(negedge clk);
    if (s_out !== 1'b1) ok = 1'b0;
  endtask

  task automatic wait_finish(output logic seen);
    int n;
    n = 0;
    while (finish !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    seen = (finish === 1'b1);
  endtask

  task automatic send_pulse(input logic [7:0] v);
    @(negedge clk);
    data  = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    int errs;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (s_out !== 1'b1 || busy !== 1'b0 || finish !== 1'b0 || state_reg !== 2'd0) begin
      bad++;
      $display("FAIL reset_hold: s_out=%b busy=%b finish=%b state=%0d want 1 0 0 0",
               s_out, busy, finish, state_reg);
    end
    reset_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_out !== 1'b1 || busy !== 1'b0 || finish !== 1'b0 || state_reg !== 2'd0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL idle_2000: %0d bad cycles, want 0", errs);
    end
  endtask

  task automatic test_frame_a5();
    logic [7:0] b;
    logic ok, seen;
    logic [9:0] exp_line;
    logic [9:0] got_line;
    exp_line = 10'b1_1010_0101_0;
    tick_mon = 0;
    fin_cnt  = 0;
    send_pulse(8'hA5);
    total++;
    if (busy !== 1'b1 || state_reg !== 2'd1) begin
      bad++;
      $display("FAIL a5_accept: busy=%b state=%0d want 1 1", busy, state_reg);
    end
    rx_frame(b, ok);
    got_line = {ok ? 1'b1 : 1'b0, b, 1'b0};
    total++;
    if (!ok || got_line !== exp_line) begin
      bad++;
      $display("FAIL a5_line: got %b ok=%b want %b", got_line, ok, exp_line);
    end
    wait_finish(seen);
    total++;
    if (!seen || tick_mon != 160) begin
      bad++;
      $display("FAIL a5_finish_ticks: seen=%b ticks=%0d want 1 160", seen, tick_mon);
    end
    @(negedge clk);
    total++;
    if (finish !== 1'b0 || busy !== 1'b0 || state_reg !== 2'd0) begin
      bad++;
      $display("FAIL a5_finish_width: finish=%b busy=%b state=%0d want 0 0 0",
               finish, busy, state_reg);
    end
    repeat (200) @(negedge clk);
    total++;
    if (fin_cnt != 1) begin
      bad++;
      $display("FAIL a5_finish_count: %0d want 1", fin_cnt);
    end
  endtask

  task automatic test_ignore_busy_start();
    logic [7:0] b;
    logic ok, seen;
    fin_cnt = 0;
    send_pulse(8'h3C);
    fork
      rx_frame(b, ok);
      begin
        repeat (400) @(negedge clk);
        data  = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    total++;
    if (!ok || b !== 8'h3C) begin
      bad++;
      $display("FAIL busy_start_data: got %h ok=%b want 3c", b, ok);
    end
    wait_finish(seen);
    repeat (400) @(negedge clk);
    total++;
    if (!seen || fin_cnt != 1 || state_reg !== 2'd0) begin
      bad++;
      $display("FAIL busy_start_finish: seen=%b count=%0d state=%0d want 1 1 0",
               seen, fin_cnt, state_reg);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic ok, seen;
    int gap;
    fin_cnt = 0;
    @(negedge clk);
    data  = 8'h00;
    start = 1'b1;
    fork
      rx_frame(b, ok);
      begin
        repeat (50) @(negedge clk);
        data = 8'hFF;
      end
    join
    total++;
    if (!ok || b !== 8'h00) begin
      bad++;
      $display("FAIL b2b_first: got %h ok=%b want 00", b, ok);
    end
    wait_finish(seen);
    gap = 0;
    while (s_out !== 1'b0 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    // Stop bit visible until one clk after finish; start bit one clk later.
    total++;
    if (!seen || gap != 2) begin
      bad++;
      $display("FAIL b2b_gap: seen=%b gap=%0d clk want 1 2", seen, gap);
    end
    fork
      rx_frame(b, ok);
      begin
        repeat (50) @(negedge clk);
        start = 1'b0;
      end
    join
    total++;
    if (!ok || b !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_second: got %h ok=%b want ff", b, ok);
    end
    wait_finish(seen);
    repeat (300) @(negedge clk);
    total++;
    if (!seen || fin_cnt != 2 || state_reg !== 2'd0) begin
      bad++;
      $display("FAIL b2b_finish: seen=%b count=%0d state=%0d want 1 2 0",
               seen, fin_cnt, state_reg);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic ok, seen;
    int n;
    fin_cnt = 0;
    send_pulse(8'h0F);
    n = 0;
    while (state_reg !== 2'd2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (720) @(negedge clk);
    total++;
    if (state_reg !== 2'd2 || s_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_pre: state=%0d s_out=%b want 2 0", state_reg, s_out);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (s_out !== 1'b1 || state_reg !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_async: s_out=%b state=%0d busy=%b want 1 0 0",
               s_out, state_reg, busy);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    total++;
    if (fin_cnt != 0 || s_out !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_nofinish: count=%0d s_out=%b want 0 1", fin_cnt, s_out);
    end
    send_pulse(8'h96);
    rx_frame(b, ok);
    total++;
    if (!ok || b !== 8'h96) begin
      bad++;
      $display("FAIL rst_mid_recover: got %h ok=%b want 96", b, ok);
    end
    wait_finish(seen);
    repeat (50) @(negedge clk);
    total++;
    if (!seen || fin_cnt != 1) begin
      bad++;
      $display("FAIL rst_mid_recover_finish: seen=%b count=%0d want 1 1", seen, fin_cnt);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] vec [4];
    logic [7:0] b;
    logic ok, seen;
    vec[0] = 8'h00;
    vec[1] = 8'h55;
    vec[2] = 8'hAA;
    vec[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      fin_cnt = 0;
      send_pulse(vec[i]);
      rx_frame(b, ok);
      total++;
      if (!ok || b !== vec[i]) begin
        bad++;
        $display("FAIL loop_data[%0d]: got %h ok=%b want %h", i, b, ok, vec[i]);
      end
      wait_finish(seen);
      repeat (30) @(negedge clk);
      total++;
      if (!seen || fin_cnt != 1) begin
        bad++;
        $display("FAIL loop_finish[%0d]: seen=%b count=%0d want 1 1", i, seen, fin_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_ignore_busy_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
